// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake bundle for seven_seg_scan_ctrl.
//   load_data  : new display value, nibble i belongs to digit i
//   load_valid : load_data is valid (source holds data until accepted)
//   load_ready : controller can accept a value
// master = value source, slave = scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] load_data;
  logic                    load_valid;
  logic                    load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit owns a slot of REFRESH_DIV cycles: the first BLANK_CYCLES are a
// blanking guard (all anodes off), the rest drive that digit's anode.
// New values arrive over a valid/ready handshake and are committed to the
// displayed (shadow) register only at the end of a frame, so a frame never
// mixes two values.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en          : scan enable (0 = dark, scan held at digit 0, cnt 0)
//   lz_en       : leading-zero suppression enable
//   ld          : load handshake (slave side)
//   digit_value : nibble for the registered hex decoder (updated at cnt==0)
//   an          : active-low anode enables
//   digit_sel   : digit index of the current slot
//   frame_done  : one-cycle pulse on the last cycle of the last digit's slot
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    lz_en,
  seven_seg_scan_ctrl_if.slave    ld,
  output logic [3:0]              digit_value,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
  output logic                    frame_done
);

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_PRE_LAST  = CNT_W'(REFRESH_DIV - 2);
  localparam logic [CNT_W-1:0]      CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0]      SEL_LAST      = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF        = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE        = NUM_DIGITS'(1);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [SEL_W-1:0]        sel_reg;
  logic [3:0]              value_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic                    frame_done_reg;
  logic [DW-1:0]           shadow_reg;
  logic [DW-1:0]           pending_reg;
  logic                    pending_flag_reg;

  logic                    xfer;
  logic                    commit;
  logic [DW-1:0]           shadow_next;
  logic [SEL_W-1:0]        sel_wrap;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS-1:0]   an_drive;
  logic [3:0]              next_nib [NUM_DIGITS];

  // Ready is simply "nothing pending": one value can be buffered at a time.
  assign xfer   = ld.load_valid & ~pending_flag_reg;
  assign commit = frame_done_reg & pending_flag_reg;

  // Value the display will use from the next cycle on; the commit edge is
  // also the edge that loads digit 0's nibble, so it must see the new value.
  assign shadow_next = commit ? pending_reg : shadow_reg;
  assign sel_wrap    = (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign next_nib[gi] = shadow_next[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign suppress[gi] = 1'b0;
      end else begin : g_upper
        // Blank when this nibble and every more significant one is zero.
        assign suppress[gi] = lz_en & ~|shadow_reg[DW-1:4*gi];
      end
    end
  endgenerate

  assign an_drive = suppress[sel_reg] ? AN_OFF : ~(AN_ONE << sel_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= GUARD;
      cnt_reg          <= '0;
      sel_reg          <= '0;
      value_reg        <= '0;
      an_reg           <= AN_OFF;
      frame_done_reg   <= 1'b0;
      shadow_reg       <= '0;
      pending_reg      <= '0;
      pending_flag_reg <= 1'b0;
    end else begin
      // xfer and commit are mutually exclusive: xfer needs the flag clear,
      // commit needs it set.
      if (xfer) begin
        pending_reg      <= ld.load_data;
        pending_flag_reg <= 1'b1;
      end else if (commit) begin
        shadow_reg       <= pending_reg;
        pending_flag_reg <= 1'b0;
      end

      if (!en) begin
        state_reg      <= GUARD;
        cnt_reg        <= '0;
        sel_reg        <= '0;
        an_reg         <= AN_OFF;
        frame_done_reg <= 1'b0;
        value_reg      <= next_nib[0];
      end else begin
        // Decoded one cycle early so the pulse is a clean register output.
        frame_done_reg <= (sel_reg == SEL_LAST) && (cnt_reg == CNT_PRE_LAST);
        if (cnt_reg == CNT_LAST) begin
          cnt_reg   <= '0;
          sel_reg   <= sel_wrap;
          state_reg <= GUARD;
          an_reg    <= AN_OFF;
          value_reg <= next_nib[sel_wrap];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
          case (state_reg)
            GUARD: begin
              if (cnt_reg == CNT_BLANK_END) begin
                state_reg <= DRIVE;
                an_reg    <= an_drive;
              end else begin
                an_reg <= AN_OFF;
              end
            end
            DRIVE: an_reg <= an_drive;
            default: begin
              state_reg <= GUARD;
              an_reg    <= AN_OFF;
            end
          endcase
        end
      end
    end
  end

  assign ld.load_ready = ~pending_flag_reg;
  assign digit_value   = value_reg;
  assign an            = an_reg;
  assign digit_sel     = sel_reg;
  assign frame_done    = frame_done_reg;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an NUM_DIGITS-digit common-anode 7-segment display.
- Feeds one 4-bit nibble at a time to the shared registered single-digit hex decoder (seg valid 1 cycle after digit_value).
- Drives the active-low digit anodes, with a ghosting guard and optional leading-zero suppression.
- Accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so a frame never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned; digit 0 = least significant (rightmost).
REFRESH_DIV, 50000, clock cycles per digit slot; must be > BLANK_CYCLES.
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-high reset.
en  input  1  scan enable; 0 = display dark, scan held.
lz_en  input  1  leading-zero suppression enable.
load_data  input  4*NUM_DIGITS  new display value; nibble i belongs to digit i.
load_valid  input  1  load_data is valid.
load_ready  output  1  controller can accept a value.
digit_value  output  4  nibble sent to the decoder.
an  output  NUM_DIGITS  anode enables, active low.
digit_sel  output  log2(NUM_DIGITS) (min 1)  index of the digit in the current slot.
frame_done  output  1  1-cycle pulse on the last cycle of digit NUM_DIGITS-1's slot.

Behaviour:
- Reset (clk edge with rst=1): an = all 1s, digit_value = 0, digit_sel = 0, frame_done = 0, load_ready = 1, slot counter = 0, shadow (displayed) register = 0, pending register = 0, pending flag = 0, FSM = GUARD.
- Reset mid-slot or mid-handshake discards any pending value; the display goes dark the next cycle.
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps.
  - At cnt==REFRESH_DIV-1, digit_sel advances; NUM_DIGITS-1 wraps to 0.
- FSM states:
  - GUARD: an = all 1s. Entered when cnt==0. Stays for BLANK_CYCLES cycles.
  - DRIVE: an[digit_sel] = 0, all other an bits = 1, unless the digit is suppressed. Entered when cnt==BLANK_CYCLES. Lasts to the end of the slot.
  - Transitions: GUARD->DRIVE at cnt==BLANK_CYCLES-1. DRIVE->GUARD at cnt==REFRESH_DIV-1.
- digit_value is registered and updated on the cycle cnt becomes 0, to shadow nibble[new digit_sel].
  - The decoder's seg output is therefore valid from cnt==1, inside the guard window. Anodes never show a stale pattern.
- Leading-zero suppression (lz_en=1): digit i (i>0) is suppressed when shadow nibbles NUM_DIGITS-1..i are all 0.
  - A suppressed digit keeps an = all 1s for its whole DRIVE phase.
  - Digit 0 is never suppressed. lz_en is sampled every cycle.
- frame_done pulses for exactly one cycle when cnt==REFRESH_DIV-1 and digit_sel==NUM_DIGITS-1.
- Load handshake:
  - Transfer occurs on a cycle where load_valid && load_ready: pending <= load_data, pending flag <= 1, load_ready <= 0 the next cycle.
  - On the frame_done cycle with pending flag = 1: shadow <= pending, pending flag <= 0, load_ready <= 1 the next cycle. The new value is first displayed on digit 0's slot.
  - A transfer and a frame_done on the same cycle: the newly accepted value becomes pending. The old pending value (none, since ready implies empty) is not affected. The commit happens at the next frame_done.
  - load_valid while ready=0 is ignored; the source must hold its data.
- en=0: synchronously forces cnt = 0, digit_sel = 0, FSM = GUARD, an = all 1s, and no frame_done.
  - The handshake still accepts a value while en=0, but commit needs a frame_done, so the value stays pending.
  - On en 0->1, scanning restarts from the start of digit 0's guard.
- Counter widths are sized to hold REFRESH_DIV-1. No overflow is possible.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
1. Reset, then en=1, no load -> digit_value 0 for every slot. an steps 1110, 1101, 1011, 0111, each low for cycles 2..7 of its slot and 1111 for cycles 0..1. frame_done pulses every 32 cycles.
2. Load 0x1A2F mid-frame -> load_ready drops the next cycle. Display keeps the old value until frame_done. The next frame shows digit_value F, 2, A, 1 for digits 0..3. load_ready returns to 1 the cycle after frame_done.
3. lz_en=1 with shadow 0x0070 -> digits 3 and 2 keep an = 1111 during DRIVE. Digits 1 and 0 drive, showing 7 and 0. With shadow 0x0000 -> only digit 0 drives, showing 0.
4. load_valid asserted exactly on the frame_done cycle with ready=1 -> value accepted but not shown in the following frame. It commits at the next frame_done.
5. Assert rst during digit 2's DRIVE with a value pending -> the next cycle has an=1111, digit_sel=0, load_ready=1, shadow=0. The pending value is never displayed.
6. Drop en for 5 cycles mid-slot -> an=1111 and no frame_done while en=0. On re-enable, the digit 0 slot restarts at cnt=0 and its first DRIVE cycle is 2 cycles later.
